vga_frame_monitor: RTL and testbench
====================================

Name: vga_frame_monitor

Overview:
- Receive-side checker for the VGA output of the Breakout top level. Samples vgaRed/vgaGreen/vgaBlue/Hsync/Vsync on the system clock.
- Recovers pixel and line position, checks sync timing against 640x480@60 parameters, and flags colour driven during blanking.
- Reports per-frame status: lit-pixel count, frame-done pulse and sticky error flags. Used in benches and as an on-chip self-check.

Parameters:
CLK_PER_PIX, 4, system clocks per pixel (100 MHz / 25 MHz); must be >= 2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
vgaRed  input  3  red from display generator
vgaGreen  input  3  green
vgaBlue  input  2  blue
Hsync  input  1  horizontal sync, active low
Vsync  input  1  vertical sync, active low
locked  output  1  high while the monitor is aligned to a frame
pix_valid  output  1  one-cycle strobe: active-region pixel sample
pix_x  output  10  column of sampled pixel, 0..H_ACTIVE-1
pix_y  output  9  row of sampled pixel, 0..V_ACTIVE-1
pix_rgb  output  8  sampled colour {R,G,B}
frame_done  output  1  one-cycle pulse at the end of each locked frame
lit_count  output  19  count of nonzero pixels in the last completed frame
h_err  output  1  sticky: bad hsync period or width
v_err  output  1  sticky: bad line count or vsync width
blank_err  output  1  sticky: nonzero RGB sampled outside the active region

Behaviour:
- Reset values: all outputs 0; FSM in ACQUIRE. Reset asynchronous at any time, including mid-frame.
- All inputs are registered once. Edges are detected on the registered copies. Output latency is 2 clk from the input edge or sample.
- HT = (H_ACTIVE+H_FP+H_SYNC+H_BP)*CLK_PER_PIX clocks. VT = V_ACTIVE+V_FP+V_SYNC+V_BP lines.
- Horizontal timing:
  - hclk counter clears to 0 on an Hsync falling edge, otherwise increments, saturating at 2*HT.
  - On each Hsync falling edge in LOCKED: if the previous line length (hclk+1) != HT, set h_err.
  - On an Hsync rising edge in LOCKED: if the low width != H_SYNC*CLK_PER_PIX, set h_err.
- Vertical timing:
  - line counter increments on each Hsync falling edge.
  - On a Vsync falling edge, line clears to 0. If the Hsync falling edge occurs in the same cycle, line = 0 and that line is line 0.
  - Vsync low width is measured in Hsync falling edges; it must equal V_SYNC, else set v_err (LOCKED only).
- FSM:
  - ACQUIRE -> LOCKED on the first Vsync falling edge.
  - LOCKED -> LOCKED on each subsequent Vsync falling edge. At that edge: if the lines in the frame just ended != VT, set v_err. Otherwise pulse frame_done and latch lit_count from the accumulator.
  - In both cases the accumulator clears at that edge.
  - LOCKED -> ACQUIRE if hclk saturates (Hsync lost). No frame_done is issued; errors are retained.
  - locked = (state == LOCKED).
- Pixel sampling:
  - The sample point is hclk mod CLK_PER_PIX == CLK_PER_PIX/2 (mid-pixel).
  - Column c = hclk/CLK_PER_PIX - (H_SYNC+H_BP). Row r = line - (V_SYNC+V_BP).
  - Active when 0 <= c < H_ACTIVE and 0 <= r < V_ACTIVE. In LOCKED, an active sample pulses pix_valid with pix_x=c, pix_y=r, pix_rgb.
  - Active and rgb != 0: the accumulator increments, saturating at 2^19-1.
  - Not active and rgb != 0, in LOCKED: set blank_err.
- Sticky errors clear only on rst. No checks run in ACQUIRE.
- Simultaneous Vsync and Hsync falling edges: the frame check uses the line count before clearing, and the new line counts as line 0 of the next frame.

Test Plan:
- Ideal generator, 640x480, 100 MHz clk, all-black frame, 2 frames: locked=1 after the first Vsync fall; frame_done pulses once, 1,680,000 clk later; lit_count=0; all errors 0.
- Single white pixel at (0,0) and one at (639,479): pix_valid shows x=0,y=0,rgb=8'hFF and x=639,y=479,rgb=8'hFF; lit_count=2 at the next frame_done.
- One line lengthened to 3204 clk: h_err=1 within 2 clk of the following Hsync fall; stays 1 through later good frames until rst.
- Frame with 524 lines: v_err=1 at the Vsync fall; no frame_done that edge; lit_count unchanged.
- Red=3'b001 driven during horizontal back porch: blank_err=1; lit_count unaffected.
- Hsync held high for 6400 clk: locked drops to 0. Assert rst mid-frame: all outputs 0 asynchronously; relock on the next Vsync fall.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA checker: recovers pixel/line position from Hsync/Vsync, checks
// sync timing, flags colour in blanking and reports per-frame lit-pixel counts.
module vga_frame_monitor #(
  parameter int unsigned CLK_PER_PIX = 4,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  vgaRed,
  input  logic [2:0]  vgaGreen,
  input  logic [1:0]  vgaBlue,
  input  logic        Hsync,
  input  logic        Vsync,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [7:0]  pix_rgb,
  output logic        frame_done,
  output logic [18:0] lit_count,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err
);

  localparam int unsigned HT    = (H_ACTIVE + H_FP + H_SYNC + H_BP) * CLK_PER_PIX;
  localparam int unsigned VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HMAX  = 2 * HT;
  localparam int unsigned HW    = $clog2(HMAX + 1);
  localparam int unsigned LMAX  = 2 * VT;
  localparam int unsigned LW    = $clog2(LMAX + 1);
  localparam int unsigned VSW   = $clog2(V_SYNC + 2) + 1;
  localparam int unsigned X_OFF = H_SYNC + H_BP;
  localparam int unsigned Y_OFF = V_SYNC + V_BP;
  localparam int unsigned CW    = 19;

  typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [7:0]      rgb_q, rgb_d;
  logic            hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic            vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic [HW-1:0]   hclk_q, hclk_d;
  logic [LW-1:0]   line_q, line_d;
  logic [VSW-1:0]  vs_lines_q, vs_lines_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic            pix_valid_q, pix_valid_d;
  logic [9:0]      pix_x_q, pix_x_d;
  logic [8:0]      pix_y_q, pix_y_d;
  logic [7:0]      pix_rgb_q, pix_rgb_d;
  logic            frame_done_q, frame_done_d;
  logic [CW-1:0]   lit_count_q, lit_count_d;
  logic            h_err_q, h_err_d;
  logic            v_err_q, v_err_d;
  logic            blank_err_q, blank_err_d;

  logic            hs_fall, hs_rise, vs_fall, vs_rise;
  logic            h_lost, in_lock, sample, active, rgb_nz;
  logic [HW-1:0]   pcol, pphase;

  always_comb begin
    rgb_d     = {vgaRed, vgaGreen, vgaBlue};
    hs_d      = Hsync;
    vs_d      = Vsync;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;

    hs_fall = hs_prev_q & ~hs_q;
    hs_rise = ~hs_prev_q & hs_q;
    vs_fall = vs_prev_q & ~vs_q;
    vs_rise = ~vs_prev_q & vs_q;
    h_lost  = (hclk_q == HW'(HMAX)) && !hs_fall;
    in_lock = (state_q == LOCKED);
    rgb_nz  = |rgb_q;

    // hclk_d is the position of the sample currently held in rgb_q
    if (hs_fall)                    hclk_d = '0;
    else if (hclk_q == HW'(HMAX))   hclk_d = hclk_q;
    else                            hclk_d = hclk_q + HW'(1);

    if (vs_fall)                              line_d = '0;
    else if (hs_fall && line_q != LW'(LMAX))  line_d = line_q + LW'(1);
    else                                      line_d = line_q;

    if (vs_fall)
      vs_lines_d = VSW'(hs_fall);
    else if (!vs_q && hs_fall && vs_lines_q != '1)
      vs_lines_d = vs_lines_q + VSW'(1);
    else
      vs_lines_d = vs_lines_q;

    pcol   = hclk_d / HW'(CLK_PER_PIX);
    pphase = hclk_d % HW'(CLK_PER_PIX);
    sample = (pphase == HW'(CLK_PER_PIX / 2));
    active = (pcol >= HW'(X_OFF)) && (pcol < HW'(X_OFF + H_ACTIVE)) &&
             (line_d >= LW'(Y_OFF)) && (line_d < LW'(Y_OFF + V_ACTIVE));

    state_d      = state_q;
    acc_d        = acc_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    frame_done_d = 1'b0;
    lit_count_d  = lit_count_q;
    h_err_d      = h_err_q;
    v_err_d      = v_err_q;
    blank_err_d  = blank_err_q;

    if (sample && active && rgb_nz && acc_q != '1)
      acc_d = acc_q + CW'(1);

    if (in_lock && sample) begin
      if (active) begin
        pix_valid_d = 1'b1;
        pix_x_d     = 10'(pcol - HW'(X_OFF));
        pix_y_d     = 9'(line_d - LW'(Y_OFF));
        pix_rgb_d   = rgb_q;
      end else if (rgb_nz) begin
        blank_err_d = 1'b1;
      end
    end

    // Sync timing checks; counters hold values from before this cycle's edge
    if (in_lock) begin
      if (hs_fall && (32'(hclk_q) + 32'd1) != HT)
        h_err_d = 1'b1;
      if (hs_rise && (32'(hclk_q) + 32'd1) != H_SYNC * CLK_PER_PIX)
        h_err_d = 1'b1;
      if (vs_rise && vs_lines_q != VSW'(V_SYNC))
        v_err_d = 1'b1;
    end

    case (state_q)
      ACQUIRE: begin
        if (vs_fall) begin
          state_d = LOCKED;
          acc_d   = '0;
        end
      end
      LOCKED: begin
        if (h_lost) begin
          state_d = ACQUIRE;
        end else if (vs_fall) begin
          acc_d = '0;
          if ((32'(line_q) + 32'd1) != VT) begin
            v_err_d = 1'b1;
          end else begin
            frame_done_d = 1'b1;
            lit_count_d  = acc_q;
          end
        end
      end
      default: state_d = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACQUIRE;
      rgb_q        <= '0;
      hs_q         <= 1'b0;
      hs_prev_q    <= 1'b0;
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      hclk_q       <= '0;
      line_q       <= '0;
      vs_lines_q   <= '0;
      acc_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
      frame_done_q <= 1'b0;
      lit_count_q  <= '0;
      h_err_q      <= 1'b0;
      v_err_q      <= 1'b0;
      blank_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      hs_prev_q    <= hs_prev_d;
      vs_q         <= vs_d;
      vs_prev_q    <= vs_prev_d;
      hclk_q       <= hclk_d;
      line_q       <= line_d;
      vs_lines_q   <= vs_lines_d;
      acc_q        <= acc_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
      frame_done_q <= frame_done_d;
      lit_count_q  <= lit_count_d;
      h_err_q      <= h_err_d;
      v_err_q      <= v_err_d;
      blank_err_q  <= blank_err_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign frame_done = frame_done_q;
  assign lit_count  = lit_count_q;
  assign h_err      = h_err_q;
  assign v_err      = v_err_q;
  assign blank_err  = blank_err_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor using a scaled-down raster so whole
// frames fit in a few hundred clocks.
module tb_vga_frame_monitor;

  localparam int CPP = 2;
  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 2;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int HTP = HA + HF + HS + HB;
  localparam int HT  = HTP * CPP;
  localparam int VT  = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vgaRed = '0;
  logic [2:0]  vgaGreen = '0;
  logic [1:0]  vgaBlue = '0;
  logic        Hsync = 1'b1;
  logic        Vsync = 1'b1;
  logic        locked, pix_valid, frame_done, h_err, v_err, blank_err;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [7:0]  pix_rgb;
  logic [18:0] lit_count;

  vga_frame_monitor #(
    .CLK_PER_PIX(CPP), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .Hsync(Hsync), .Vsync(Vsync), .locked(locked), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_done(frame_done),
    .lit_count(lit_count), .h_err(h_err), .v_err(v_err), .blank_err(blank_err)
  );

  initial forever #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  longint      cyc = 0;
  logic [26:0] pix_q[$];
  logic [18:0] done_q[$];
  longint      done_cyc[$];
  logic [7:0]  img [VA][HA];
  int          long_line = -1;
  int          long_extra = 0;
  int          red_line = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic hs, input logic vs, input logic [7:0] rgb);
    @(negedge clk);
    Hsync = hs;
    Vsync = vs;
    {vgaRed, vgaGreen, vgaBlue} = rgb;
  endtask

  // One raster line: sync, back porch, active, front porch (plus optional stretch)
  task automatic gen_line(input int l, input bit expect_pix);
    for (int p = 0; p < HTP; p++) begin
      for (int k = 0; k < CPP; k++) begin
        int r;
        int c;
        bit act;
        logic [7:0] rgb;
        r = l - (VS + VB);
        c = p - (HS + HB);
        act = (r >= 0) && (r < VA) && (c >= 0) && (c < HA);
        if (act)                          rgb = img[r][c];
        else if (l == red_line && p == HS) rgb = 8'h20;
        else                              rgb = 8'h00;
        drive(p >= HS, l >= VS, rgb);
        if (act && expect_pix && k == CPP / 2)
          pix_q.push_back({10'(c), 9'(r), rgb});
      end
    end
    if (l == long_line)
      for (int e = 0; e < long_extra; e++) drive(1'b1, l >= VS, 8'h00);
  endtask

  task automatic gen_frame(input int nlines, input bit expect_pix);
    for (int l = 0; l < nlines; l++) gen_line(l, expect_pix);
  endtask

  task automatic clear_img();
    for (int r = 0; r < VA; r++)
      for (int c = 0; c < HA; c++) img[r][c] = 8'h00;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
    chk({tag, "_pix_x"}, 32'(pix_x), 0);
    chk({tag, "_pix_y"}, 32'(pix_y), 0);
    chk({tag, "_pix_rgb"}, 32'(pix_rgb), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_lit_count"}, 32'(lit_count), 0);
    chk({tag, "_h_err"}, 32'(h_err), 0);
    chk({tag, "_v_err"}, 32'(v_err), 0);
    chk({tag, "_blank_err"}, 32'(blank_err), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel or frame result
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (pix_valid) begin
      if (pix_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=0x%0h required none", pix_x, pix_y, pix_rgb);
      end else begin
        logic [26:0] e;
        e = pix_q.pop_front();
        chk("pix", {5'b0, pix_x, pix_y, pix_rgb}, {5'b0, e});
      end
    end
    if (frame_done) begin
      done_cyc.push_back(cyc);
      if (done_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL frame_done_unexpected: got lit_count=%0d required no pulse", lit_count);
      end else begin
        logic [18:0] e;
        e = done_q.pop_front();
        chk("frame_done_lit", 32'(lit_count), 32'(e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_img();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (10) drive(1'b1, 1'b1, 8'h00);

    // Frame A: black, lock acquired at its vsync fall
    gen_frame(VT, 1'b1);
    chk("A_locked", 32'(locked), 1);
    chk("A_h_err", 32'(h_err), 0);
    chk("A_v_err", 32'(v_err), 0);
    chk("A_blank_err", 32'(blank_err), 0);

    // Frame B: corner pixels lit
    img[0][0] = 8'hFF;
    img[VA-1][HA-1] = 8'hFF;
    done_q.push_back(19'd0);
    gen_frame(VT, 1'b1);

    clear_img();
    done_q.push_back(19'd2);
    gen_frame(VT, 1'b1);
    chk("C_lit_count", 32'(lit_count), 2);
    chk("C_h_err", 32'(h_err), 0);
    chk("C_v_err", 32'(v_err), 0);
    if (done_cyc.size() >= 2)
      chk("done_period", 32'(done_cyc[1] - done_cyc[0]), 32'(HT * VT));
    else begin
      n_checks++;
      n_errors++;
      $display("FAIL done_period: got %0d pulses required 2", done_cyc.size());
    end

    // Frame D: line 5 stretched by 4 clocks, one lit pixel
    img[2][3] = 8'hFF;
    long_line = 5;
    long_extra = 4;
    done_q.push_back(19'd0);
    for (int l = 0; l < 6; l++) gen_line(l, 1'b1);
    chk("D_h_err_before", 32'(h_err), 0);
    fork
      gen_line(6, 1'b1);
      begin
        repeat (3) @(negedge clk);
        #1;
        chk("D_h_err_2clk", 32'(h_err), 1);
      end
    join
    gen_line(7, 1'b1);
    gen_line(8, 1'b1);
    long_line = -1;
    chk("D_v_err", 32'(v_err), 0);

    // Frame E: one line short
    clear_img();
    img[1][2] = 8'hFF;
    done_q.push_back(19'd1);
    gen_frame(VT - 1, 1'b1);
    chk("E_lit_count", 32'(lit_count), 1);
    chk("E_blank_err", 32'(blank_err), 0);
    chk("E_v_err", 32'(v_err), 0);

    // Frame F: red in horizontal back porch; its start reports the short frame
    clear_img();
    red_line = 5;
    gen_frame(VT, 1'b1);
    red_line = -1;
    chk("F_v_err", 32'(v_err), 1);
    chk("F_lit_unchanged", 32'(lit_count), 1);
    chk("F_blank_err", 32'(blank_err), 1);
    chk("F_h_err_sticky", 32'(h_err), 1);

    done_q.push_back(19'd0);
    gen_frame(VT, 1'b1);
    chk("G_lit_count", 32'(lit_count), 0);
    chk("G_locked", 32'(locked), 1);

    // Hsync lost: monitor must drop lock, keep errors
    repeat (70) drive(1'b1, 1'b1, 8'h00);
    chk("loss_locked", 32'(locked), 0);
    chk("loss_h_err", 32'(h_err), 1);
    chk("loss_v_err", 32'(v_err), 1);

    // Frame H: relock, then asynchronous reset mid-frame
    gen_line(0, 1'b0);
    gen_line(1, 1'b0);
    chk("H_locked", 32'(locked), 1);
    chk("H_pix_x_prev", 32'(pix_x), HA - 1);
    fork
      gen_line(2, 1'b0);
      begin
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
      end
    join
    for (int l = 3; l < VT; l++) gen_line(l, 1'b0);
    chk("H_locked_after_rst", 32'(locked), 0);

    gen_frame(VT, 1'b1);
    chk("I_locked", 32'(locked), 1);
    done_q.push_back(19'd0);
    gen_frame(VT, 1'b1);
    repeat (5) drive(1'b1, 1'b1, 8'h00);
    chk("J_h_err", 32'(h_err), 0);
    chk("J_v_err", 32'(v_err), 0);
    chk("J_blank_err", 32'(blank_err), 0);
    chk("pix_q_drained", 32'(pix_q.size()), 0);
    chk("done_q_drained", 32'(done_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
